// File: rtl/cvi_stream_rx_if.sv
// Avalon-ST video packet bus carried out of the clocked-video receiver.
// The source drives data/valid/sop/eop; the sink returns ready.
interface cvi_stream_rx_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              sop;
  logic              eop;
  logic              ready;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/cvi_stream_rx.sv
// Clocked-video receiver: locks onto vsync, recovers frames from datavalid,
// measures width/height and re-emits pixels as an Avalon-ST packet stream
// through a show-ahead FIFO. A one-pixel hold register lets the final pixel
// of a frame be tagged eop when the closing vsync edge arrives.
module cvi_stream_rx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              vid_datavalid,
  input  logic              vid_h_sync,
  input  logic              vid_v_sync,
  cvi_stream_rx_if.master   st,
  output logic [CNT_W-1:0]  frame_width,
  output logic [CNT_W-1:0]  frame_height,
  output logic              frame_done,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOP,
    S_ACTIVE,
    S_DISCARD
  } state_t;

  state_t             r_state;
  logic               r_vs_q;
  logic               r_dv_q;
  logic [DATA_W-1:0]  r_hold_data;
  logic               r_hold_sop;
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [CNT_W-1:0]   r_line_cnt;
  logic [CNT_W-1:0]   r_last_w;
  logic [EW-1:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;

  logic               w_vs_rise;
  logic               w_dv_fall;
  logic               w_pix;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push_req;
  logic               w_can_push;
  logic               w_push;
  logic               w_drop;
  logic [EW-1:0]      w_push_entry;
  logic [EW-1:0]      w_head;
  logic [CNT_W-1:0]   w_pix_inc;
  logic [CNT_W-1:0]   w_line_inc;
  logic               w_unused_hsync;

  // hsync is monitored only; line boundaries come from datavalid
  assign w_unused_hsync = vid_h_sync;

  assign w_vs_rise = vid_v_sync & ~r_vs_q;
  assign w_dv_fall = ~vid_datavalid & r_dv_q;
  // vsync wins over a coincident valid pixel, which is treated as blanking
  assign w_pix     = vid_datavalid & ~w_vs_rise;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_pop   = ~w_empty & st.ready;

  // The held pixel leaves when the next pixel arrives or the frame closes
  assign w_push_req   = (r_state == S_ACTIVE) & (w_pix | w_vs_rise);
  assign w_can_push   = ~w_full | w_pop;
  assign w_push       = w_push_req & w_can_push;
  assign w_drop       = w_push_req & ~w_can_push;
  assign w_push_entry = {r_hold_sop, w_vs_rise, r_hold_data};

  assign w_pix_inc  = (&r_pix_cnt)  ? r_pix_cnt  : r_pix_cnt  + CNT_W'(1);
  assign w_line_inc = (&r_line_cnt) ? r_line_cnt : r_line_cnt + CNT_W'(1);

  assign st.valid = ~w_empty;
  assign st.sop   = ~w_empty & w_head[EW-1];
  assign st.eop   = ~w_empty & w_head[EW-2];
  assign st.data  = w_empty ? '0 : w_head[DATA_W-1:0];

  // FIFO storage: written on accepted pushes, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_push_entry;
    end
  end

  // FIFO pointers; reset empties the queue
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW + 1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW + 1)'(1);
    end
  end

  // Frame FSM: edge history, hold register, line/pixel counters, status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_vs_q       <= 1'b0;
      r_dv_q       <= 1'b0;
      r_hold_data  <= '0;
      r_hold_sop   <= 1'b0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_last_w     <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_done   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      r_vs_q     <= vid_v_sync;
      r_dv_q     <= vid_datavalid;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vs_rise) r_state <= S_WAIT_SOP;
        end
        S_WAIT_SOP: begin
          if (w_pix) begin
            r_hold_data <= vid_data;
            r_hold_sop  <= 1'b1;
            r_pix_cnt   <= CNT_W'(1);
            r_line_cnt  <= '0;
            r_last_w    <= '0;
            r_state     <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_drop) begin
            overflow <= 1'b1;
            // a drop on the closing vsync edge has already seen its boundary
            r_state  <= w_vs_rise ? S_WAIT_SOP : S_DISCARD;
          end else if (w_vs_rise) begin
            frame_done <= 1'b1;
            // a nonzero pixel count means the last line is still open
            if (r_pix_cnt != '0) begin
              frame_width  <= r_pix_cnt;
              frame_height <= w_line_inc;
            end else begin
              frame_width  <= r_last_w;
              frame_height <= r_line_cnt;
            end
            r_state <= S_WAIT_SOP;
          end else if (w_pix) begin
            r_hold_data <= vid_data;
            r_hold_sop  <= 1'b0;
            r_pix_cnt   <= w_pix_inc;
          end else if (w_dv_fall) begin
            r_line_cnt <= w_line_inc;
            r_last_w   <= r_pix_cnt;
            r_pix_cnt  <= '0;
          end
        end
        S_DISCARD: begin
          if (w_vs_rise) r_state <= S_WAIT_SOP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cvi_stream_rx.sv
// Bench for cvi_stream_rx: frames are described as lines x width; the expected
// packet (pixel order, sop on first, eop on last, width/height) is derived from
// that description into a queue and compared beat by beat on a monitor.
module tb_cvi_stream_rx;

  localparam int DW = 24;
  localparam int CW = 12;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int lines;
    int width;
    int rmode;     // 0 always ready, 1 toggle, 2 random, 3 stalled
    bit coincide;  // vsync rises with datavalid still high
    int gap;
    int exp_w;
    int exp_h;
    int exp_beats;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] vid_data = '0;
  logic          vid_datavalid = 1'b0;
  logic          vid_h_sync = 1'b0;
  logic          vid_v_sync = 1'b0;
  logic [CW-1:0] fw, fh, fw4, fh4;
  logic          fd, fd4, ovf, ovf4;

  cvi_stream_rx_if #(.DATA_W(DW)) st_if ();
  cvi_stream_rx_if #(.DATA_W(DW)) st4_if ();

  cvi_stream_rx #(.DATA_W(DW), .FIFO_DEPTH(16), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .st(st_if),
    .frame_width(fw), .frame_height(fh), .frame_done(fd), .overflow(ovf)
  );

  cvi_stream_rx #(.DATA_W(DW), .FIFO_DEPTH(4), .CNT_W(CW)) u_dut4 (
    .clk(clk), .reset(reset), .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .st(st4_if),
    .frame_width(fw4), .frame_height(fh4), .frame_done(fd4), .overflow(ovf4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_pass = 0;
  int    n_total = 0;
  int    rmode = 0;
  bit    en4 = 1'b0;
  beat_t exp0[$];
  beat_t exp4[$];
  int    beats0 = 0, sop0 = 0, eop0 = 0, done0 = 0;
  int    beats4 = 0, sop4 = 0, eop4 = 0, done4 = 0;
  int    cyc_vs = 0, cyc_eop = 0;
  beat_t mb, me;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every accepted beat must match the head of the expected queue
  always @(negedge clk) begin
    if (fd) done0++;
    if (st_if.valid && st_if.ready) begin
      mb = {st_if.sop, st_if.eop, st_if.data};
      beats0++;
      if (mb.sop) sop0++;
      if (mb.eop) begin eop0++; cyc_eop = cyc; end
      chk("beat_expected", 32'(exp0.size() != 0), 32'd1);
      if (exp0.size() != 0) begin
        me = exp0.pop_front();
        chk("beat", 32'(mb), 32'(me));
      end
    end
    if (en4) begin
      if (fd4) done4++;
      if (st4_if.valid && st4_if.ready) begin
        mb = {st4_if.sop, st4_if.eop, st4_if.data};
        beats4++;
        if (mb.sop) sop4++;
        if (mb.eop) eop4++;
        chk("beat4_expected", 32'(exp4.size() != 0), 32'd1);
        if (exp4.size() != 0) begin
          me = exp4.pop_front();
          chk("beat4", 32'(mb), 32'(me));
        end
      end
    end
  end

  // Downstream ready pattern for the main instance
  initial begin
    st_if.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       st_if.ready = 1'b1;
        1:       st_if.ready = ~st_if.ready;
        2:       st_if.ready = ($urandom_range(3) != 0);
        default: st_if.ready = 1'b0;
      endcase
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vid_datavalid = 1'b0;
    vid_v_sync = 1'b0;
    step();
    step();
    exp0.delete();
    exp4.delete();
    reset = 1'b0;
  endtask

  task automatic vsync_pulse();
    vid_v_sync = 1'b1;
    step();
    step();
    vid_v_sync = 1'b0;
    step();
  endtask

  task automatic send_frame(input int lines, input int width, input bit coincide,
                            input int gap, input int dest);
    beat_t e;
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < width; p++) begin
        vid_data = DW'($urandom);
        vid_datavalid = 1'b1;
        e = {1'(l == 0 && p == 0), 1'(l == lines - 1 && p == width - 1), vid_data};
        if (dest == 0) exp0.push_back(e);
        else exp4.push_back(e);
        step();
      end
      if (!(coincide && l == lines - 1)) begin
        vid_datavalid = 1'b0;
        vid_h_sync = 1'b1;
        step();
        vid_h_sync = 1'b0;
        repeat (gap - 1) step();
      end
    end
    vid_v_sync = 1'b1;
    if (coincide) begin
      vid_datavalid = 1'b1;
      vid_data = DW'($urandom);
    end
    cyc_vs = cyc;
    step();
    vid_datavalid = 1'b0;
    step();
    step();
    vid_v_sync = 1'b0;
    step();
  endtask

  task automatic wait_drain(input int dest, input int budget);
    int k = 0;
    while (((dest == 0) ? exp0.size() : exp4.size()) != 0 && k < budget) begin
      step();
      k++;
    end
    chk("drain", 32'((dest == 0) ? exp0.size() : exp4.size()), 32'd0);
    repeat (3) step();
  endtask

  vec_t vecs[5];
  int   b0, s0, e0, d0, b4, s4, e4, d4;
  int   exp_total, lines, width, gap;
  bit   coin;

  initial begin
    vecs[0] = '{lines: 3, width: 4, rmode: 0, coincide: 1'b0, gap: 2, exp_w: 4, exp_h: 3, exp_beats: 12};
    vecs[1] = '{lines: 2, width: 8, rmode: 1, coincide: 1'b0, gap: 3, exp_w: 8, exp_h: 2, exp_beats: 16};
    vecs[2] = '{lines: 2, width: 3, rmode: 0, coincide: 1'b1, gap: 2, exp_w: 3, exp_h: 2, exp_beats: 6};
    vecs[3] = '{lines: 1, width: 1, rmode: 0, coincide: 1'b0, gap: 1, exp_w: 1, exp_h: 1, exp_beats: 1};
    vecs[4] = '{lines: 4, width: 5, rmode: 2, coincide: 1'b0, gap: 6, exp_w: 5, exp_h: 4, exp_beats: 20};

    st4_if.ready = 1'b1;
    do_reset();

    // reset state
    chk("rst_valid", 32'(st_if.valid), 32'd0);
    chk("rst_sop", 32'(st_if.sop), 32'd0);
    chk("rst_eop", 32'(st_if.eop), 32'd0);
    chk("rst_width", 32'(fw), 32'd0);
    chk("rst_height", 32'(fh), 32'd0);
    chk("rst_done", 32'(fd), 32'd0);
    chk("rst_overflow", 32'(ovf), 32'd0);

    // pixels before the first vsync are ignored
    b0 = beats0;
    for (int i = 0; i < 6; i++) begin
      vid_data = DW'($urandom);
      vid_datavalid = 1'b1;
      step();
    end
    vid_datavalid = 1'b0;
    repeat (4) step();
    chk("prelock_beats", 32'(beats0 - b0), 32'd0);
    chk("prelock_width", 32'(fw), 32'd0);
    chk("prelock_height", 32'(fh), 32'd0);

    // table of frame shapes
    vsync_pulse();
    foreach (vecs[i]) begin
      b0 = beats0; s0 = sop0; e0 = eop0; d0 = done0;
      rmode = vecs[i].rmode;
      send_frame(vecs[i].lines, vecs[i].width, vecs[i].coincide, vecs[i].gap, 0);
      wait_drain(0, 300);
      rmode = 0;
      chk("vec_beats", 32'(beats0 - b0), 32'(vecs[i].exp_beats));
      chk("vec_sop", 32'(sop0 - s0), 32'd1);
      chk("vec_eop", 32'(eop0 - e0), 32'd1);
      chk("vec_width", 32'(fw), 32'(vecs[i].exp_w));
      chk("vec_height", 32'(fh), 32'(vecs[i].exp_h));
      chk("vec_done", 32'(done0 - d0), 32'd1);
      chk("vec_overflow", 32'(ovf), 32'd0);
      if (vecs[i].rmode == 0) chk("eop_latency", 32'(cyc_eop - cyc_vs), 32'd1);
    end

    // overflow on the 4-deep instance with the sink stalled
    rmode = 3;
    st4_if.ready = 1'b0;
    do_reset();
    en4 = 1'b1;
    b4 = beats4; s4 = sop4; e4 = eop4; d4 = done4;
    vsync_pulse();
    for (int p = 0; p < 6; p++) begin
      vid_data = DW'($urandom);
      vid_datavalid = 1'b1;
      if (p < 4) exp4.push_back({1'(p == 0), 1'b0, vid_data});
      step();
      if (p == 4) chk("ovf_before", 32'(ovf4), 32'd0);
      if (p == 5) chk("ovf_at_6th", 32'(ovf4), 32'd1);
    end
    vid_datavalid = 1'b0;
    step();
    vsync_pulse();
    chk("ovf_no_done", 32'(done4 - d4), 32'd0);
    chk("ovf_held", 32'(st4_if.valid), 32'd1);
    st4_if.ready = 1'b1;
    wait_drain(1, 100);
    chk("ovf_beats", 32'(beats4 - b4), 32'd4);
    chk("ovf_no_eop", 32'(eop4 - e4), 32'd0);
    send_frame(1, 2, 1'b0, 2, 1);
    wait_drain(1, 100);
    chk("ovf_next_sop", 32'(sop4 - s4), 32'd2);
    chk("ovf_next_eop", 32'(eop4 - e4), 32'd1);
    chk("ovf_sticky", 32'(ovf4), 32'd1);
    chk("ovf_next_done", 32'(done4 - d4), 32'd1);
    en4 = 1'b0;

    // reset in the middle of a frame abandons the partial packet
    do_reset();
    rmode = 0;
    vsync_pulse();
    rmode = 3;
    for (int p = 0; p < 3; p++) begin
      vid_data = DW'($urandom);
      vid_datavalid = 1'b1;
      step();
    end
    b0 = beats0;
    do_reset();
    chk("midrst_valid", 32'(st_if.valid), 32'd0);
    rmode = 0;
    step();
    chk("midrst_valid2", 32'(st_if.valid), 32'd0);
    s0 = sop0; e0 = eop0;
    vsync_pulse();
    send_frame(2, 2, 1'b0, 2, 0);
    wait_drain(0, 100);
    chk("midrst_beats", 32'(beats0 - b0), 32'd4);
    chk("midrst_sop", 32'(sop0 - s0), 32'd1);
    chk("midrst_eop", 32'(eop0 - e0), 32'd1);
    chk("midrst_width", 32'(fw), 32'd2);
    chk("midrst_height", 32'(fh), 32'd2);

    // random frames against the frame-shape model
    rmode = 2;
    b0 = beats0; d0 = done0;
    exp_total = 0;
    for (int f = 0; f < 25; f++) begin
      lines = $urandom_range(4, 1);
      width = $urandom_range(6, 1);
      coin  = 1'($urandom_range(1, 0));
      gap   = $urandom_range(width + 3, width + 1);
      exp_total += lines * width;
      send_frame(lines, width, coin, gap, 0);
      chk("rnd_width", 32'(fw), 32'(width));
      chk("rnd_height", 32'(fh), 32'(lines));
    end
    wait_drain(0, 500);
    chk("rnd_beats", 32'(beats0 - b0), 32'(exp_total));
    chk("rnd_done", 32'(done0 - d0), 32'd25);
    chk("rnd_overflow", 32'(ovf), 32'd0);
    rmode = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
